id_operand_stage: RTL
=====================

# id_operand_stage

Parametrised successor to the ID stage that handles operand fetch, forwarding, load-use interlock and branch resolution.
- Takes pre-decoded instructions from the decoder over a valid/ready handshake.
- Reads the regfile and resolves operands from NFWD forwarding sources.
- Interlocks on in-flight loads of configurable latency and resolves branches and `jr`.
- Holds the result in an ID/EX register with its own valid/ready handshake to EX.

## Interface
Parameters:
- DATA_W, 32, data/PC width
- RADDR_W, 5, register address width
- NFWD, 2, forwarding sources; index 0 is youngest and has highest priority
- LOAD_LAT, 1, cycles after a load leaves ID/EX before its data appears on a forwarding port (0..7)
- CTRL_W, 16, opaque control payload (aluop/alusel) passed through

Ports (`name direction width meaning`):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid / in_ready  in / out  1 / 1  decoder handshake
- in_pc  in  DATA_W  instruction PC
- in_ctrl  in  CTRL_W  payload
- in_rs_addr, in_rt_addr  in  RADDR_W  source registers
- in_rs_use, in_rt_use  in  1  source registers actually read
- in_imm  in  DATA_W  immediate, used as op2 when in_rt_use=0
- in_wd  in  RADDR_W  destination register
- in_wreg  in  1  writes a register
- in_is_load  in  1  instruction is a load
- in_br  in  2  branch kind: 0 none, 1 beq, 2 bne, 3 jr
- in_br_target  in  DATA_W  target for beq/bne
- rf_raddr1, rf_raddr2  out  RADDR_W  regfile read addresses (combinational)
- rf_rdata1, rf_rdata2  in  DATA_W  regfile read data (same cycle)
- fwd_valid  in  NFWD  forwarding source writes a register
- fwd_addr  in  NFWD*RADDR_W  forwarding destination addresses
- fwd_data  in  NFWD*DATA_W  forwarding data
- out_valid / out_ready  out / in  1 / 1  EX handshake
- out_pc, out_ctrl, out_op1, out_op2, out_wd, out_wreg, out_is_load, out_in_delay_slot  out  to EX
- br_taken  out  1  one-cycle pulse
- br_target  out  DATA_W  redirect address
- stall_o  out  1  hazard interlock is active this cycle

## Operation
- Register 0 always reads 0. It is never forwarded and never causes a hazard.
- Operand resolution, per operand:
  - the lowest-index fwd entry with valid=1 and an address match wins;
  - otherwise the regfile data is used.
  - op2 = in_imm when in_rt_use=0.
  - Operands with use=0 are never checked for hazards.
- Hazard: a used nonzero source matches either of these:
  - (a) out_valid & out_is_load & out_wreg & out_wd;
  - (b) pend_cnt≠0 & pend_addr.
- stall_o = in_valid & hazard.
- in_ready = ~hazard & (~out_valid | out_ready).
- Accept = in_valid & in_ready. On accept, the ID/EX register loads all out_* fields; out_valid=1.
- If out_ready & ~accept, then out_valid→0 and the fields are held.
- Pending-load tracker:
  - When the load in ID/EX is consumed (out_valid & out_ready & out_is_load & out_wreg & out_wd≠0): pend_addr←out_wd, pend_cnt←LOAD_LAT. This overwrites any earlier pending load.
  - Otherwise pend_cnt decrements while nonzero.
- Branch resolution on accept, using resolved operands:
  - beq: taken iff op1==op2.
  - bne: taken iff op1≠op2.
  - jr: always taken, target = op1.
  - Otherwise target = in_br_target.
- Delay slot:
  - ds_pending is set on accept of any in_br≠0.
  - The next accepted instruction gets out_in_delay_slot=1 and clears ds_pending.
- Link-value computation stays in the decoder payload; this block does not compute it.

## Timing
- Reset values: every output register and the internal state (ID/EX fields, out_valid, br_taken, br_target, pend_cnt, pend_addr, ds_pending) are 0.
- ID to EX latency is 1 cycle. Throughput is 1 instruction per cycle with no hazards and out_ready=1.
- br_taken and br_target are registered and appear on the cycle after accept, for exactly one cycle.
- A stalled branch does not resolve until its hazard clears.
- With a load-use hazard where the consumer immediately follows the load and out_ready=1, the consumer is held LOAD_LAT+1 cycles. It accepts in the cycle the load result is presented on a forwarding port.
- Simultaneous consumption of one load and accept of the next load: the tracker takes the old load and the ID/EX register takes the new one.
- Reset mid-stall clears the tracker and ds_pending immediately (asynchronous).

## Structure
- Package id_pkg holds:
  - the branch kind constants BR_NONE/BR_EQ/BR_NE/BR_JR;
  - the widths CTRL_W and DATA_W defaults.
- Sub-module id_fwd_mux, parametrised by NFWD, DATA_W and RADDR_W, is instantiated once per operand. It is purely combinational priority select with a zero-register override.
- The tracker, ID/EX register and delay-slot flag live in the top level.

## Test plan
- Forwarding priority:
  - Stimulus: rs=3, regfile=0x11, fwd[1]={1,3,0x22}, fwd[0]={1,3,0x33}.
  - Response: out_op1=0x33. With fwd[0].valid=0: 0x22. With rs=0: 0 despite a fwd match on addr 0.
- Load-use, LOAD_LAT=2:
  - Stimulus: lw r5, then add r6,r5,r1 back-to-back, out_ready=1.
  - Response: stall_o high 3 cycles, in_ready low 3 cycles, add accepted on the 4th with the forwarded r5.
- Backpressure:
  - Stimulus: out_ready=0 for 4 cycles with in_valid=1.
  - Response: in_ready=0, out_* stable, no lost or duplicated instruction after release.
- Branch:
  - beq with op1=op2=7 and target 0x400: br_taken pulses 1 cycle later with br_target=0x400.
  - bne with equal operands: no pulse.
  - jr r31=0x1234: target 0x1234.
- Delay slot: branch, then next accept has out_in_delay_slot=1; the following accept has 0.
- Asynchronous reset: rst low mid-stall, with pend_cnt=2 and out_valid=1, forces all outputs to 0 without a clock edge.

Source files
------------

// File: rtl/id_pkg.sv
// Shared constants for the ID operand stage: branch kinds, default widths and
// the branch-decision helper used at accept time.
package id_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int CTRL_W_DEF  = 16;
    localparam int RADDR_W_DEF = 5;
    localparam int PEND_CNT_W  = 3;

    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_EQ   = 2'd1;
    localparam logic [1:0] BR_NE   = 2'd2;
    localparam logic [1:0] BR_JR   = 2'd3;

    function automatic logic br_resolve(input logic [1:0] kind, input logic ops_equal);
        logic taken;
        taken = 1'b0;
        case (kind)
            BR_EQ:   taken = ops_equal;
            BR_NE:   taken = ~ops_equal;
            BR_JR:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Per-operand forwarding select: lowest-index matching source wins over the
// regfile, and register 0 is forced to zero regardless of any match.
module id_fwd_mux
    import id_pkg::*;
#(
    parameter int NFWD    = 2,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic [RADDR_W-1:0]      addr,
    input  logic [NFWD-1:0]         fwd_valid,
    input  logic [NFWD*RADDR_W-1:0] fwd_addr,
    input  logic [NFWD*DATA_W-1:0]  fwd_data,
    input  logic [DATA_W-1:0]       rf_data,
    output logic [DATA_W-1:0]       data
);

    always_comb begin
        data = rf_data;
        // Walk from oldest to youngest so the youngest match is the last writer.
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_addr[i*RADDR_W +: RADDR_W] == addr)) begin
                data = fwd_data[i*DATA_W +: DATA_W];
            end
        end
        if (addr == '0) begin
            data = '0;
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// ID stage: operand fetch with forwarding, load-use interlock against the
// ID/EX load and a pending-load tracker, branch resolution and the ID/EX register.
module id_operand_stage
    import id_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RADDR_W  = RADDR_W_DEF,
    parameter int NFWD     = 2,
    parameter int LOAD_LAT = 1,
    parameter int CTRL_W   = CTRL_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_pc,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [RADDR_W-1:0]      in_rs_addr,
    input  logic [RADDR_W-1:0]      in_rt_addr,
    input  logic                    in_rs_use,
    input  logic                    in_rt_use,
    input  logic [DATA_W-1:0]       in_imm,
    input  logic [RADDR_W-1:0]      in_wd,
    input  logic                    in_wreg,
    input  logic                    in_is_load,
    input  logic [1:0]              in_br,
    input  logic [DATA_W-1:0]       in_br_target,
    output logic [RADDR_W-1:0]      rf_raddr1,
    output logic [RADDR_W-1:0]      rf_raddr2,
    input  logic [DATA_W-1:0]       rf_rdata1,
    input  logic [DATA_W-1:0]       rf_rdata2,
    input  logic [NFWD-1:0]         fwd_valid,
    input  logic [NFWD*RADDR_W-1:0] fwd_addr,
    input  logic [NFWD*DATA_W-1:0]  fwd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_pc,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [DATA_W-1:0]       out_op1,
    output logic [DATA_W-1:0]       out_op2,
    output logic [RADDR_W-1:0]      out_wd,
    output logic                    out_wreg,
    output logic                    out_is_load,
    output logic                    out_in_delay_slot,
    output logic                    br_taken,
    output logic [DATA_W-1:0]       br_target,
    output logic                    stall_o
);

    logic [DATA_W-1:0]     rs_val, rt_val, op1, op2;
    logic                  rs_hz, rt_hz, hazard, accept, load_consumed;

    logic                  valid_q, valid_d;
    logic [DATA_W-1:0]     pc_q, pc_d;
    logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
    logic [DATA_W-1:0]     op1_q, op1_d;
    logic [DATA_W-1:0]     op2_q, op2_d;
    logic [RADDR_W-1:0]    wd_q, wd_d;
    logic                  wreg_q, wreg_d;
    logic                  is_load_q, is_load_d;
    logic                  in_ds_q, in_ds_d;
    logic                  br_taken_q, br_taken_d;
    logic [DATA_W-1:0]     br_target_q, br_target_d;
    logic [PEND_CNT_W-1:0] pend_cnt_q, pend_cnt_d;
    logic [RADDR_W-1:0]    pend_addr_q, pend_addr_d;
    logic                  ds_pending_q, ds_pending_d;

    assign rf_raddr1 = in_rs_addr;
    assign rf_raddr2 = in_rt_addr;

    id_fwd_mux #(.NFWD(NFWD), .DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_rs (
        .addr      (in_rs_addr),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .rf_data   (rf_rdata1),
        .data      (rs_val)
    );

    id_fwd_mux #(.NFWD(NFWD), .DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_rt (
        .addr      (in_rt_addr),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .rf_data   (rf_rdata2),
        .data      (rt_val)
    );

    assign op1 = rs_val;
    assign op2 = in_rt_use ? rt_val : in_imm;

    // A source collides with the load sitting in ID/EX or with a load whose
    // data has not yet reached a forwarding port.
    always_comb begin
        rs_hz = in_rs_use && (in_rs_addr != '0) &&
                ((valid_q && is_load_q && wreg_q && (wd_q == in_rs_addr)) ||
                 ((pend_cnt_q != '0) && (pend_addr_q == in_rs_addr)));
        rt_hz = in_rt_use && (in_rt_addr != '0) &&
                ((valid_q && is_load_q && wreg_q && (wd_q == in_rt_addr)) ||
                 ((pend_cnt_q != '0) && (pend_addr_q == in_rt_addr)));
        hazard = rs_hz || rt_hz;
    end

    assign stall_o       = in_valid && hazard;
    assign in_ready      = !hazard && (!valid_q || out_ready);
    assign accept        = in_valid && in_ready;
    assign load_consumed = valid_q && out_ready && is_load_q && wreg_q && (wd_q != '0);

    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        ctrl_d       = ctrl_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        wd_d         = wd_q;
        wreg_d       = wreg_q;
        is_load_d    = is_load_q;
        in_ds_d      = in_ds_q;
        br_taken_d   = 1'b0;
        br_target_d  = br_target_q;
        ds_pending_d = ds_pending_q;
        pend_cnt_d   = pend_cnt_q;
        pend_addr_d  = pend_addr_q;

        if (accept) begin
            valid_d      = 1'b1;
            pc_d         = in_pc;
            ctrl_d       = in_ctrl;
            op1_d        = op1;
            op2_d        = op2;
            wd_d         = in_wd;
            wreg_d       = in_wreg;
            is_load_d    = in_is_load;
            in_ds_d      = ds_pending_q;
            ds_pending_d = (in_br != BR_NONE);
            br_taken_d   = br_resolve(in_br, op1 == op2);
            br_target_d  = (in_br == BR_JR) ? op1 : in_br_target;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        // The tracker always follows the load leaving ID/EX, even if a newer
        // load enters ID/EX on the same edge.
        if (load_consumed) begin
            pend_addr_d = wd_q;
            pend_cnt_d  = PEND_CNT_W'(LOAD_LAT);
        end else if (pend_cnt_q != '0) begin
            pend_cnt_d = pend_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            ctrl_q       <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            wd_q         <= '0;
            wreg_q       <= 1'b0;
            is_load_q    <= 1'b0;
            in_ds_q      <= 1'b0;
            br_taken_q   <= 1'b0;
            br_target_q  <= '0;
            pend_cnt_q   <= '0;
            pend_addr_q  <= '0;
            ds_pending_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            ctrl_q       <= ctrl_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            wd_q         <= wd_d;
            wreg_q       <= wreg_d;
            is_load_q    <= is_load_d;
            in_ds_q      <= in_ds_d;
            br_taken_q   <= br_taken_d;
            br_target_q  <= br_target_d;
            pend_cnt_q   <= pend_cnt_d;
            pend_addr_q  <= pend_addr_d;
            ds_pending_q <= ds_pending_d;
        end
    end

    assign out_valid         = valid_q;
    assign out_pc            = pc_q;
    assign out_ctrl          = ctrl_q;
    assign out_op1           = op1_q;
    assign out_op2           = op2_q;
    assign out_wd            = wd_q;
    assign out_wreg          = wreg_q;
    assign out_is_load       = is_load_q;
    assign out_in_delay_slot = in_ds_q;
    assign br_taken          = br_taken_q;
    assign br_target         = br_target_q;

endmodule
